// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// A grant lasts until the packet ends, the burst limit is hit, or the owner drops valid.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters, starting after last_grant
// GRANT | grant_id owns the write port; FIFO full stalls without releasing
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IDW:0]    NUM_REQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [BW-1:0]   MAX_BURST_W = BW'(MAX_BURST);
  localparam logic [IDW-1:0]  LAST_INIT   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            busy_q, busy_d;

  logic [IDW:0]    cand;
  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  logic            g_valid, g_last, xfer;
  logic [BW-1:0]   beat_inc;

  // Wrap-around search starting one past the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!pick_found && req_valid[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[IDW-1:0];
      end
    end
  end

  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign xfer     = (state_q == GRANT) && g_valid && !fifo_full;
  assign beat_inc = beat_cnt_q + BW'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_d    = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) beat_cnt_d = beat_inc;
        // A stalled owner that keeps valid high holds the grant.
        if (!g_valid || (xfer && (g_last || beat_inc == MAX_BURST_W))) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_comb begin
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    if (state_q == GRANT) begin
      req_ready[grant_q] = !fifo_full;
      fifo_write_en      = xfer;
      fifo_data_in       = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_INIT;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write side of one synchronous FIFO among NUM_REQ producers.
- Arbitrates round-robin and grants one requester at a time for a burst of up to MAX_BURST beats.
- Drives the FIFO's write_en/data_in and back-pressures requesters from the FIFO full flag.
- Sits between producer blocks and the FIFO write port; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, data width per beat; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..255).
- IDW (localparam), max(1, clog2(NUM_REQ)), width of grant_id.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a requester's packet.
- req_ready  out  NUM_REQ  per-requester ready; a beat transfers when valid && ready.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_id  out  IDW  index of the current or last granted requester.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, beat_cnt=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
  - All outputs low/zero.
- States:
  - IDLE: if any req_valid is high, pick the first requester with valid high, searching (last_grant+1) mod NUM_REQ upward with wrap. Register it in grant_id, clear beat_cnt, go to GRANT. Arbitration costs 1 cycle; req_ready stays 0 in IDLE.
  - GRANT, g = grant_id:
    - req_ready[g] = !fifo_full; every other req_ready bit is 0.
    - fifo_write_en = req_valid[g] && !fifo_full (combinational from registered state and inputs).
    - fifo_data_in = req_data slice g while in GRANT, 0 otherwise.
    - Each transfer increments beat_cnt.
- Release (GRANT -> IDLE next edge, last_grant <= g) on the first of:
  - a transfer with req_last[g]=1;
  - a transfer that makes beat_cnt == MAX_BURST;
  - req_valid[g]=0 in any GRANT cycle (requester abandoned the grant).
- After release there is 1 IDLE cycle before the next grant. A requester still valid re-competes with round-robin priority after all others.
- fifo_full high in GRANT: stall. Grant is held, no transfer, beat_cnt unchanged, fifo_write_en=0. This is not a release condition while req_valid[g] stays high.
- Simultaneous req_last and beat_cnt reaching MAX_BURST: single release, no double-count.
- fifo_write_en never asserts while fifo_full=1, so the FIFO never sees a write when full.
- grant_id holds its value in IDLE; busy = (state==GRANT).
- Reset mid-burst: immediate abort, priority restarts at requester 0; beats already written stay in the FIFO.
- Requester changes on req_valid/req_data without a transfer are ignored; there is no protocol check.

Test Plan:
- Reset, then req_valid=4'b0001, 3 beats 0xA1,0xA2,0xA3 with last on 0xA3 -> grant_id=0 one cycle after valid; 3 consecutive writes; busy falls after 0xA3; last_grant=0.
- req_valid=4'b1111 held, all last=0, MAX_BURST=4 -> grants in order 0,1,2,3,0; 4 writes each; 1 idle cycle between grants.
- Requester 2 granted, fifo_full=1 for 5 cycles mid-burst -> fifo_write_en=0 and req_ready=0 during the stall; burst resumes at the next beat with no lost or duplicated data; total beats = 4.
- Requester 1 granted, drops req_valid after 2 beats -> release; next grant goes to the next valid requester after 1 (e.g. 3 if 3 is valid).
- reset_n pulsed low during requester 3's 2nd beat -> outputs zero immediately; after release with req_valid=4'b1001, requester 0 is granted first.
- last on beat 4 with MAX_BURST=4 -> exactly 4 writes, single release, next grant after 1 idle cycle.
